// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main control FSM of the multi-cycle MIPS CPU.
// Steps each instruction through IF/ID/EX/MEM/WB and drives the datapath
// mux selects, write enables and the 4-bit ALUOp for the ALU control decoder.
// Optional build macro MAIN_CTRL_ILLEGAL_TRAP_EN: unsupported instructions
// trap into S_HALT (IllegalInst=1) instead of retiring as a NOP.
// All control outputs are registered. Each output register holds the decode
// of the state register, so the outputs behave as Moore outputs of that state.
module multicycle_main_control #(
  parameter int ALUOP_W = 4,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         RegDst,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic               LuiOp,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               IllegalInst
);

  typedef enum logic [STATE_W-1:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_MADDR = 4'd2,
    S_MRD   = 4'd3,
    S_WBL   = 4'd4,
    S_MWR   = 4'd5,
    S_EXR   = 4'd6,
    S_WBR   = 4'd7,
    S_EXI   = 4'd8,
    S_WBI   = 4'd9,
    S_BEQ   = 4'd10,
    S_J     = 4'd11,
    S_JR    = 4'd12,
    S_HALT  = 4'd13
  } state_t;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic [1:0]         mem_to_reg;
    logic [1:0]         reg_dst;
    logic               reg_write;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic               ext_op;
    logic               lui_op;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  state_t state_r;
  state_t next_s;
  ctrl_t  ctrl_r;
  logic   restart_r;   // set by reset: the first cycle after reset is a fresh fetch

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  logic   illegal_r;

  // R-type function codes this CPU implements
  function automatic logic is_legal_funct(input logic [5:0] fn);
    logic ok;
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2a, 6'h2b: ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  // Next-state transition for a state given the current instruction fields
  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn);
    state_t n;
    n = S_IF;
    case (s)
      S_IF:    n = S_ID;
      S_ID: begin
        case (op)
          6'h23, 6'h2b: n = S_MADDR;
          6'h00: begin
            if ((fn == 6'h08) || (fn == 6'h09)) begin
              n = S_JR;
            end else begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
              n = is_legal_funct(fn) ? S_EXR : S_HALT;
`else
              n = S_EXR;
`endif
            end
          end
          6'h04:        n = S_BEQ;
          6'h02, 6'h03: n = S_J;
          6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b: n = S_EXI;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
          default:      n = S_HALT;
`else
          default:      n = S_IF;
`endif
        endcase
      end
      S_MADDR: n = (op == 6'h23) ? S_MRD : S_MWR;
      S_MRD:   n = S_WBL;
      S_EXR:   n = S_WBR;
      S_EXI:   n = S_WBI;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      S_HALT:  n = S_HALT;
`endif
      default: n = S_IF;   // write-back/branch/jump states and unused codes
    endcase
    return n;
  endfunction

  // Datapath control word asserted while in state s
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op,
                                   input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      S_ID: begin
        c.alu_src_b = 2'b11;   // branch target into ALUOut
        c.ext_op    = 1'b1;
      end
      S_MADDR: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.ext_op    = 1'b1;
      end
      S_MRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_WBL: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b01;
      end
      S_MWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXR: begin
        c.alu_op = 4'b0010;
        // shifts by shamt take the shift amount on the A port
        if ((fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03)) begin
          c.alu_src_a = 2'b10;
        end else begin
          c.alu_src_a = 2'b01;
        end
      end
      S_WBR: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 2'b01;
      end
      S_EXI: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        case (op)
          6'h08, 6'h09: c.ext_op = 1'b1;
          6'h0c:        c.alu_op = 4'b0011;
          6'h0a: begin
            c.alu_op = 4'b0100;
            c.ext_op = 1'b1;
          end
          6'h0b: begin
            c.alu_op = 4'b0101;
            c.ext_op = 1'b1;
          end
          6'h0f:        c.lui_op = 1'b1;
          default:      c.alu_op = 4'b0000;
        endcase
      end
      S_WBI: c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a     = 2'b01;
        c.alu_op        = 4'b0001;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_J: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        if (op == 6'h03) begin   // jal links into $31
          c.reg_write  = 1'b1;
          c.reg_dst    = 2'b10;
          c.mem_to_reg = 2'b10;
        end else begin
          c.reg_write = 1'b0;
        end
      end
      S_JR: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b11;
        if (fn == 6'h09) begin   // jalr links into rd
          c.reg_write  = 1'b1;
          c.reg_dst    = 2'b01;
          c.mem_to_reg = 2'b10;
        end else begin
          c.reg_write = 1'b0;
        end
      end
      default: c = '0;         // S_HALT and unused encodings drive nothing
    endcase
    return c;
  endfunction

  // Select the state for the coming cycle; after reset always start a fetch
  always_comb begin
    next_s = S_IF;
    if (restart_r) begin
      next_s = S_IF;
    end else begin
      next_s = next_state(state_r, OpCode, Funct);
    end
  end

  // State register and registered control word; reset silences all enables
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IF;
      ctrl_r    <= '0;
      restart_r <= 1'b1;
    end else begin
      state_r   <= next_s;
      ctrl_r    <= decode(next_s, OpCode, Funct);
      restart_r <= 1'b0;
    end
  end

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
  // Illegal-instruction flag, held for as long as the FSM sits in S_HALT
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= (next_s == S_HALT);
    end
  end

  assign IllegalInst = illegal_r;
`else
  assign IllegalInst = 1'b0;
`endif

  assign PCWrite     = ctrl_r.pc_write;
  assign PCWriteCond = ctrl_r.pc_write_cond;
  assign IorD        = ctrl_r.iord;
  assign MemRead     = ctrl_r.mem_read;
  assign MemWrite    = ctrl_r.mem_write;
  assign IRWrite     = ctrl_r.ir_write;
  assign MemtoReg    = ctrl_r.mem_to_reg;
  assign RegDst      = ctrl_r.reg_dst;
  assign RegWrite    = ctrl_r.reg_write;
  assign ALUSrcA     = ctrl_r.alu_src_a;
  assign ALUSrcB     = ctrl_r.alu_src_b;
  assign ExtOp       = ctrl_r.ext_op;
  assign LuiOp       = ctrl_r.lui_op;
  assign PCSource    = ctrl_r.pc_source;
  assign ALUOp       = ctrl_r.alu_op;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: the stimulus process pushes
// the hand-written expected control word for each cycle; a monitor pops and
// compares it against the outputs shortly after every rising edge.
module tb_multicycle_main_control;

  logic       clk;
  logic       reset;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic [1:0] MemtoReg, RegDst;
  logic       RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB;
  logic       ExtOp, LuiOp;
  logic [1:0] PCSource;
  logic [3:0] ALUOp;
  logic       IllegalInst;

  multicycle_main_control dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .PCSource(PCSource), .ALUOp(ALUOp), .IllegalInst(IllegalInst)
  );

  // Packed word order:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg[2],RegDst[2],
  //  RegWrite,ALUSrcA[2],ALUSrcB[2],ExtOp,LuiOp,PCSource[2],ALUOp[4],IllegalInst}
  function automatic logic [24:0] w(
    input logic pcw, input logic pcwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic [1:0] mtr, input logic [1:0] rd,
    input logic rw, input logic [1:0] asa, input logic [1:0] asb, input logic ext,
    input logic lui, input logic [1:0] pcs, input logic [3:0] aop, input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, mtr, rd, rw, asa, asb, ext, lui, pcs, aop, ill};
  endfunction

  logic [24:0] actual;
  assign actual = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtOp, LuiOp, PCSource,
                   ALUOp, IllegalInst};

  typedef struct {
    string       name;
    logic [24:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [24:0] e_zero, e_if, e_id, e_maddr, e_mrd, e_wbl, e_mwr, e_exr_sh, e_wbr;
  logic [24:0] e_exi_add, e_exi_lui, e_wbi, e_beq, e_jal, e_jalr, e_halt;

  initial begin
    //                pw pc io mr mw ir mtr    rd     rw asa    asb    ex lu pcs    aluop    il
    e_zero    = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0);
    e_if      = w(1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 2'b00, 2'b01, 0, 0, 2'b00, 4'b0000, 0);
    e_id      = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b11, 1, 0, 2'b00, 4'b0000, 0);
    e_maddr   = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b10, 1, 0, 2'b00, 4'b0000, 0);
    e_mrd     = w(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0);
    e_wbl     = w(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0);
    e_mwr     = w(0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0);
    e_exr_sh  = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b10, 2'b00, 0, 0, 2'b00, 4'b0010, 0);
    e_wbr     = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0);
    e_exi_add = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b10, 1, 0, 2'b00, 4'b0000, 0);
    e_exi_lui = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b10, 0, 1, 2'b00, 4'b0000, 0);
    e_wbi     = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 0);
    e_beq     = w(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0, 0, 2'b01, 4'b0001, 0);
    e_jal     = w(1, 0, 0, 0, 0, 0, 2'b10, 2'b10, 1, 2'b00, 2'b00, 0, 0, 2'b10, 4'b0000, 0);
    e_jalr    = w(1, 0, 0, 0, 0, 0, 2'b10, 2'b01, 1, 2'b00, 2'b00, 0, 0, 2'b11, 4'b0000, 0);
    e_halt    = w(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 2'b00, 4'b0000, 1);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs (before the next rising edge) and queue the
  // outputs expected right after that edge.
  task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input string nm, input logic [24:0] e);
    exp_t x;
    reset  = r;
    OpCode = op;
    Funct  = fn;
    x.name = nm;
    x.val  = e;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: compare DUT outputs against the scoreboard after each edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        total++;
        if (actual !== x.val) begin
          bad++;
          $display("FAIL %s t=%0t got=%07h want=%07h", x.name, $time, actual, x.val);
        end
      end
    end
  end

  // Stimulus: directed instruction sequence
  initial begin
    #1;
    step(1'b1, 6'h00, 6'h00, "rst0", e_zero);
    step(1'b1, 6'h00, 6'h00, "rst1", e_zero);
    // lw
    step(1'b0, 6'h23, 6'h00, "lw_if", e_if);
    step(1'b0, 6'h23, 6'h00, "lw_id", e_id);
    step(1'b0, 6'h23, 6'h00, "lw_maddr", e_maddr);
    step(1'b0, 6'h23, 6'h00, "lw_mrd", e_mrd);
    step(1'b0, 6'h23, 6'h00, "lw_wbl", e_wbl);
    // sra
    step(1'b0, 6'h00, 6'h03, "sra_if", e_if);
    step(1'b0, 6'h00, 6'h03, "sra_id", e_id);
    step(1'b0, 6'h00, 6'h03, "sra_exr", e_exr_sh);
    step(1'b0, 6'h00, 6'h03, "sra_wbr", e_wbr);
    // beq
    step(1'b0, 6'h04, 6'h00, "beq_if", e_if);
    step(1'b0, 6'h04, 6'h00, "beq_id", e_id);
    step(1'b0, 6'h04, 6'h00, "beq_ex", e_beq);
    // jal
    step(1'b0, 6'h03, 6'h00, "jal_if", e_if);
    step(1'b0, 6'h03, 6'h00, "jal_id", e_id);
    step(1'b0, 6'h03, 6'h00, "jal_j", e_jal);
    // jalr
    step(1'b0, 6'h00, 6'h09, "jalr_if", e_if);
    step(1'b0, 6'h00, 6'h09, "jalr_id", e_id);
    step(1'b0, 6'h00, 6'h09, "jalr_jr", e_jalr);
    // sw
    step(1'b0, 6'h2b, 6'h00, "sw_if", e_if);
    step(1'b0, 6'h2b, 6'h00, "sw_id", e_id);
    step(1'b0, 6'h2b, 6'h00, "sw_maddr", e_maddr);
    step(1'b0, 6'h2b, 6'h00, "sw_mwr", e_mwr);
    // addi
    step(1'b0, 6'h08, 6'h00, "addi_if", e_if);
    step(1'b0, 6'h08, 6'h00, "addi_id", e_id);
    step(1'b0, 6'h08, 6'h00, "addi_exi", e_exi_add);
    step(1'b0, 6'h08, 6'h00, "addi_wbi", e_wbi);
    // lw aborted by reset while in S_MRD: no write-back may follow
    step(1'b0, 6'h23, 6'h00, "lwab_if", e_if);
    step(1'b0, 6'h23, 6'h00, "lwab_id", e_id);
    step(1'b0, 6'h23, 6'h00, "lwab_maddr", e_maddr);
    step(1'b0, 6'h23, 6'h00, "lwab_mrd", e_mrd);
    step(1'b1, 6'h23, 6'h00, "lwab_rst", e_zero);
    // unsupported opcode 0x3f
    step(1'b0, 6'h3f, 6'h00, "ill_if", e_if);
    step(1'b0, 6'h3f, 6'h00, "ill_id", e_id);
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    step(1'b0, 6'h3f, 6'h00, "ill_halt0", e_halt);
    step(1'b0, 6'h3f, 6'h00, "ill_halt1", e_halt);
    step(1'b0, 6'h3f, 6'h00, "ill_halt2", e_halt);
`else
    step(1'b0, 6'h3f, 6'h00, "nop_if", e_if);
    step(1'b0, 6'h3f, 6'h00, "nop_id", e_id);
    step(1'b0, 6'h3f, 6'h00, "nop_if2", e_if);
`endif
    step(1'b1, 6'h0f, 6'h00, "rst2", e_zero);
    // lui after reset
    step(1'b0, 6'h0f, 6'h00, "lui_if", e_if);
    step(1'b0, 6'h0f, 6'h00, "lui_id", e_id);
    step(1'b0, 6'h0f, 6'h00, "lui_exi", e_exi_lui);
    step(1'b0, 6'h0f, 6'h00, "lui_wbi", e_wbi);
    // bounded drain of the scoreboard
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout reached t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM of the multi-cycle MIPS CPU.
- Decodes OpCode/Funct from the instruction register and steps each instruction through IF/ID/EX/MEM/WB.
- Drives the datapath mux selects and write enables.
- Supplies the 4-bit ALUOp consumed by the ALU control decoder, which resolves it to the ALU configuration and Sign.

Parameters:
- ALUOP_W, 4, width of ALUOp output.
- STATE_W, 4, width of state register.

Ports:
- clk input 1 system clock, rising edge.
- reset input 1 synchronous, active-high reset.
- OpCode input 6 IR[31:26].
- Funct input 6 IR[5:0].
- PCWrite output 1 unconditional PC write.
- PCWriteCond output 1 PC write if ALU Zero (beq).
- IorD output 1 memory address: 0=PC, 1=ALUOut.
- MemRead output 1 memory read.
- MemWrite output 1 memory write.
- IRWrite output 1 load instruction register.
- MemtoReg output 2 write-back source: 00 ALUOut, 01 MDR, 10 PC (link).
- RegDst output 2 destination: 00 rt, 01 rd, 10 $31.
- RegWrite output 1 register file write.
- ALUSrcA output 2 ALU A input: 00 PC, 01 reg A, 10 shamt.
- ALUSrcB output 2 ALU B input: 00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- ExtOp output 1 1=sign-extend, 0=zero-extend.
- LuiOp output 1 select imm<<16.
- PCSource output 2 next PC: 00 ALU result, 01 ALUOut, 10 jump target, 11 reg A.
- ALUOp output 4 0000 add, 0001 sub, 0010 R-type (use Funct), 0011 and, 0100 slt signed, 0101 slt unsigned.
- IllegalInst output 1 see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. A high reset sampled at the rising edge forces state to S_IF.
- While reset is high, all outputs are 0. This includes every write enable, so no PC, IR, register file or memory write can occur.
- Output timing: Moore outputs decoded from the state register. In S_ID and later states the decode also uses OpCode/Funct, which are stable because IRWrite is 0 after S_IF.
- Next-state logic: registered. Exactly one state per cycle.
- S_IF: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=00, ALUSrcB=01, ALUOp=0000, PCSource=00, PCWrite=1 -> S_ID.
- S_ID: ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUOp=0000 (branch target into ALUOut). Dispatch by OpCode:
  - 0x23/0x2b -> S_MADDR
  - 0x00 with Funct 0x08/0x09 -> S_JR
  - other 0x00 -> S_EXR
  - 0x04 -> S_BEQ
  - 0x02/0x03 -> S_J
  - 0x0f/0x08/0x09/0x0c/0x0a/0x0b -> S_EXI
  - anything else -> S_IF (NOP)
- S_MADDR: ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=0000. Goes to S_MRD for lw, S_MWR for sw.
- S_MRD: MemRead=1, IorD=1 -> S_WBL.
- S_WBL: RegWrite=1, RegDst=00, MemtoReg=01 -> S_IF.
- S_MWR: MemWrite=1, IorD=1 -> S_IF.
- S_EXR: ALUOp=0010, ALUSrcB=00. ALUSrcA=10 for Funct 0x00/0x02/0x03, else 01 -> S_WBR.
- S_WBR: RegWrite=1, RegDst=01, MemtoReg=00 -> S_IF.
- S_EXI: ALUSrcA=01, ALUSrcB=10.
  - addi/addiu: ALUOp 0000, ExtOp 1.
  - andi: ALUOp 0011, ExtOp 0.
  - slti: ALUOp 0100, ExtOp 1.
  - sltiu: ALUOp 0101, ExtOp 1.
  - lui: LuiOp 1, ALUOp 0000.
  - -> S_WBI.
- S_WBI: RegWrite=1, RegDst=00, MemtoReg=00 -> S_IF.
- S_BEQ: ALUSrcA=01, ALUSrcB=00, ALUOp=0001, PCWriteCond=1, PCSource=01 -> S_IF.
- S_J: PCWrite=1, PCSource=10. For jal also RegWrite=1, RegDst=10, MemtoReg=10 -> S_IF.
- S_JR: PCWrite=1, PCSource=11. For jalr also RegWrite=1, RegDst=01, MemtoReg=10 -> S_IF.
- Latencies in cycles, IF to next IF:
  - lw 5
  - sw, R-type, I-type ALU 4
  - beq, j, jal, jr, jalr 3
  - unsupported opcode 2
- Default for any output not listed in a state: 0.
- Unused state encodings -> S_IF next cycle, all outputs 0.
- Reset mid-instruction: abandons it. No write enable asserts in the reset cycle. Fetch restarts in the cycle after reset deasserts.

Optional Feature:
- Macro: MAIN_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported OpCode, or OpCode 0x00 with Funct outside {00,02,03,08,09,20-27,2a,2b}, moves S_ID -> S_HALT.
- S_HALT: IllegalInst=1 and all other outputs 0. Stays there until reset.
- Undefined: such instructions return to S_IF as a NOP, and IllegalInst is tied 0.

Test Plan:
- reset=1 for 2 cycles, then 0 -> all outputs 0 during reset. Next cycle state S_IF with IRWrite=1, PCWrite=1, ALUOp=0000.
- OpCode=0x23 (lw) -> states IF,ID,MADDR,MRD,WBL. RegWrite=1 with MemtoReg=01 in cycle 5 only. Next IF in cycle 6.
- OpCode=0x00, Funct=0x03 (sra) -> EXR with ALUSrcA=10, ALUOp=0010. RegWrite=1, RegDst=01 in cycle 4.
- OpCode=0x04 (beq) -> cycle 3 has PCWriteCond=1, ALUOp=0001, PCSource=01. Back to IF in cycle 4.
- OpCode=0x03 (jal) then OpCode=0x00/Funct=0x09 (jalr) -> cycle 3 has PCWrite=1 and RegWrite=1 with MemtoReg=10. RegDst is 10 for jal, 01 for jalr. PCSource is 10 for jal, 11 for jalr.
- OpCode=0x3f, with reset asserted during S_MRD of a preceding lw:
  - No RegWrite pulse for the aborted lw.
  - 0x3f returns to IF after 2 cycles, or with MAIN_CTRL_ILLEGAL_TRAP_EN holds IllegalInst=1 until reset.
